bp_result_display: RTL and testbench

Downstream consumer of the BP network top. It captures the 10-bit network result on each rising edge of `finish`. It converts the captured value to 4-digit BCD with a sequential shift-add-3 engine, then drives a 4-digit multiplexed 7-segment display. It also exposes the BCD value, with a valid pulse, for other consumers.

---
 rtl/bp_result_display.sv | 160 ++++++++++++++++
 tb/tb_bp_result_display.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_result_display.sv
// Captures the network result, converts it to BCD with shift-add-3,
// and scans it onto a 4-digit multiplexed 7-segment display.
module bp_result_display #(
  parameter int SCAN_DIV      = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        finish,
  input  logic [9:0]  result,
  output logic        busy,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic [7:0]  seg,
  output logic [3:0]  dig_sel
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int CW = $clog2(SCAN_DIV);

  state_t        state;
  state_t        state_nx;
  logic          finish_d;
  logic          fedge;
  logic          pending;
  logic [9:0]    pend_val;
  logic [25:0]   sr;
  logic [25:0]   sr_adj;
  logic [3:0]    iter;
  logic          load;
  logic          shift_en;
  logic          done;
  logic          store_pend;
  logic [CW-1:0] scan_cnt;
  logic          scan_wrap;
  logic [1:0]    idx;
  logic [1:0]    idx_nx;
  logic [3:0]    nib;
  logic          blank;

  assign fedge = finish & ~finish_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (fedge || pending) state_nx = SHIFT;
      SHIFT: if (iter == 4'd9)     state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load       = (state == IDLE) && (fedge || pending);
    shift_en   = (state == SHIFT);
    done       = (state == DONE);
    store_pend = fedge && (state != IDLE);
  end

  // Add-3 on every BCD nibble that is 5 or more, before the shift
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 4; i++) begin
      if (sr[10+4*i +: 4] >= 4'd5)
        sr_adj[10+4*i +: 4] = sr[10+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      finish_d  <= 1'b0;
      pending   <= 1'b0;
      pend_val  <= '0;
      sr        <= '0;
      iter      <= '0;
      busy      <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      finish_d  <= finish;
      bcd_valid <= 1'b0;
      if (load) begin
        sr   <= {16'b0, fedge ? result : pend_val};
        iter <= '0;
        busy <= 1'b1;
      end
      if (shift_en) begin
        sr   <= {sr_adj[24:0], 1'b0};
        iter <= iter + 4'd1;
      end
      if (done) begin
        bcd       <= sr[25:10];
        bcd_valid <= 1'b1;
        busy      <= 1'b0;
      end
      if (store_pend) begin
        pending  <= 1'b1;
        pend_val <= result;
      end else if (load) begin
        pending <= 1'b0;
      end
    end
  end

  assign scan_wrap = (scan_cnt == CW'(SCAN_DIV - 1));
  assign idx_nx    = scan_wrap ? idx + 2'd1 : idx;
  assign nib       = bcd[4*idx_nx +: 4];

  always_comb begin
    blank = 1'b0;
    unique case (idx_nx)
      2'd3: blank = (bcd[15:12] == 4'd0);
      2'd2: blank = (bcd[15:8] == 8'd0);
      2'd1: blank = (bcd[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
    blank = blank & BLANK_LEADING;
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    unique case (n)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      dig_sel  <= 4'hF;
      seg      <= 8'hFF;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + CW'(1);
      idx      <= idx_nx;
      dig_sel  <= ~(4'b0001 << idx_nx);
      seg      <= {1'b1, blank ? 7'h7F : seg7(nib)};
    end
  end

endmodule

// File: tb/tb_bp_result_display.sv
// Bench for bp_result_display: directed tables, corner sequences and
// randomized captures against a cycle-level decimal reference model.
module tb_bp_result_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        finish = 1'b0;
  logic [9:0]  result = '0;
  logic        busy, busy0;
  logic [15:0] bcd, bcd0;
  logic        bcd_valid, bcd_valid0;
  logic [7:0]  seg, seg0;
  logic [3:0]  dig_sel, dig_sel0;

  always #5 clk = ~clk;

  bp_result_display #(.SCAN_DIV(SD), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .finish(finish), .result(result),
    .busy(busy), .bcd(bcd), .bcd_valid(bcd_valid),
    .seg(seg), .dig_sel(dig_sel)
  );

  bp_result_display #(.SCAN_DIV(SD), .BLANK_LEADING(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .finish(finish), .result(result),
    .busy(busy0), .bcd(bcd0), .bcd_valid(bcd_valid0),
    .seg(seg0), .dig_sel(dig_sel0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   t = 0;
  bit   fprev = 0;
  bit   active = 0;
  int   start_t = 0;
  int   cur = 0;
  bit   pend = 0;
  int   pval = 0;
  int   exp_val = 0;
  bit   exp_valid = 0;
  int   scnt = 0;
  int   sidx = 0;
  logic [7:0] exp_seg1 = 8'hFF;
  logic [7:0] exp_seg0 = 8'hFF;
  logic [3:0] exp_dig = 4'hF;

  int nvalid = 0;
  bit seen7 = 0;

  localparam logic [7:0] CODES [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam int P10 [4] = '{1, 10, 100, 1000};

  function automatic logic [15:0] tobcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] segof(input int v, input int i,
                                       input bit bl);
    int p;
    p = P10[i];
    if (bl && i > 0 && v < p) return 8'hFF;
    return CODES[(v / p) % 10];
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h",
               name, t, act, req);
    end
  endtask

  task automatic model(input bit f, input int r, input bit rn);
    bit fe;
    t++;
    exp_valid = 0;
    if (!rn) begin
      fprev = 0; active = 0; pend = 0; exp_val = 0;
      scnt = 0; sidx = 0;
      exp_seg1 = 8'hFF; exp_seg0 = 8'hFF; exp_dig = 4'hF;
      return;
    end
    if (scnt == SD - 1) begin
      scnt = 0;
      sidx = (sidx + 1) % 4;
    end else begin
      scnt++;
    end
    exp_dig  = ~(4'(1) << sidx);
    exp_seg1 = segof(exp_val, sidx, 1'b1);
    exp_seg0 = segof(exp_val, sidx, 1'b0);
    fe = f && !fprev;
    fprev = f;
    if (active && t == start_t + 11) begin
      exp_val = cur; exp_valid = 1; active = 0;
      if (fe) begin pend = 1; pval = r; end
    end else if (active) begin
      if (fe) begin pend = 1; pval = r; end
    end else if (fe) begin
      active = 1; start_t = t; cur = r; pend = 0;
    end else if (pend) begin
      active = 1; start_t = t; cur = pval; pend = 0;
    end
  endtask

  task automatic compare();
    chk("busy", 32'(busy), 32'(active));
    chk("bcd_valid", 32'(bcd_valid), 32'(exp_valid));
    chk("bcd", 32'(bcd), 32'(tobcd(exp_val)));
    chk("seg", 32'(seg), 32'(exp_seg1));
    chk("dig_sel", 32'(dig_sel), 32'(exp_dig));
    chk("bcd_nb", 32'(bcd0), 32'(tobcd(exp_val)));
    chk("seg_nb", 32'(seg0), 32'(exp_seg0));
    chk("dig_sel_nb", 32'(dig_sel0), 32'(exp_dig));
    if (bcd_valid) begin
      nvalid++;
      if (bcd == 16'h0007) seen7 = 1;
    end
  endtask

  task automatic step(input bit f, input int r, input bit rn);
    finish = f;
    result = 10'(r);
    rst_n  = rn;
    @(posedge clk);
    model(f, r, rn);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  typedef struct {
    int          v;
    logic [15:0] b;
    logic [31:0] s1;
    logic [31:0] s0;
  } vec_t;

  vec_t tbl [10];
  logic [7:0] got1 [4];
  logic [7:0] got0 [4];

  initial begin
    tbl[0] = '{1023, 16'h1023, 32'hF9C0A4B0, 32'hF9C0A4B0};
    tbl[1] = '{999,  16'h0999, 32'hFF909090, 32'hC0909090};
    tbl[2] = '{0,    16'h0000, 32'hFFFFFFC0, 32'hC0C0C0C0};
    tbl[3] = '{5,    16'h0005, 32'hFFFFFF92, 32'hC0C0C092};
    tbl[4] = '{45,   16'h0045, 32'hFFFF9992, 32'hC0C09992};
    tbl[5] = '{512,  16'h0512, 32'hFF92F9A4, 32'hC092F9A4};
    tbl[6] = '{100,  16'h0100, 32'hFFF9C0C0, 32'hC0F9C0C0};
    tbl[7] = '{1000, 16'h1000, 32'hF9C0C0C0, 32'hF9C0C0C0};
    tbl[8] = '{10,   16'h0010, 32'hFFFFF9C0, 32'hC0C0F9C0};
    tbl[9] = '{678,  16'h0678, 32'hFF82F880, 32'hC082F880};

    @(negedge clk);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    idle(20);

    step(1, 1023, 1);
    idle(20);
    chk("t2_bcd", 32'(bcd), 32'h1023);

    nvalid = 0;
    for (int i = 0; i < 20; i++) step(1, 999, 1);
    idle(10);
    chk("t3_one_valid", 32'(nvalid), 32'd1);
    chk("t3_bcd", 32'(bcd), 32'h0999);

    nvalid = 0;
    seen7 = 0;
    step(1, 512, 1);
    idle(3);
    step(1, 7, 1);
    idle(1);
    step(1, 45, 1);
    idle(25);
    chk("t4_valids", 32'(nvalid), 32'd2);
    chk("t4_no7", 32'(seen7), 32'd0);
    chk("t4_bcd", 32'(bcd), 32'h0045);

    nvalid = 0;
    step(1, 300, 1);
    idle(4);
    step(0, 0, 0);
    idle(15);
    chk("t5_no_valid", 32'(nvalid), 32'd0);
    chk("t5_bcd", 32'(bcd), 32'h0000);
    step(1, 0, 1);
    idle(14);
    chk("t5_valid", 32'(nvalid), 32'd1);

    for (int e = 0; e < 10; e++) begin
      bit got;
      got = 0;
      step(1, tbl[e].v, 1);
      for (int i = 0; i < 20 && !got; i++) begin
        step(0, 0, 1);
        got = bcd_valid;
      end
      chk("tbl_timeout", 32'(got), 32'd1);
      chk("tbl_bcd", 32'(bcd), 32'(tbl[e].b));
      step(0, 0, 1);
      for (int i = 0; i < 4; i++) begin
        got1[i] = 8'h00;
        got0[i] = 8'h00;
      end
      for (int c = 0; c < 4 * SD; c++) begin
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
          if (dig_sel == ~(4'(1) << i)) got1[i] = seg;
          if (dig_sel0 == ~(4'(1) << i)) got0[i] = seg0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        chk("tbl_seg", 32'(got1[i]), 32'(tbl[e].s1[8*i +: 8]));
        chk("tbl_seg_nb", 32'(got0[i]), 32'(tbl[e].s0[8*i +: 8]));
      end
    end

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) == 0, int'($urandom_range(0, 1023)),
           $urandom_range(0, 99) != 0);
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
